// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: opcode encodings and flag bit positions.
package alu_pkg;

  // Opcodes; every operation is computed as B op A.
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  // Bit positions inside the 3-bit flags word {ovf, carry, zero}.
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, LSB-first on A.
// done/product are asserted combinationally during the final iteration so the caller can
// register the result on the same edge that retires the last partial product.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;

  // Accumulator value after the current iteration's partial product is added.
  always_comb begin
    acc_next = acc_reg + (a_reg[0] ? b_reg : '0);
  end

  assign busy    = busy_reg;
  assign done    = busy_reg && (cnt_reg == CW'(WIDTH - 1));
  assign product = acc_next;

  // Operand capture on start, then one shift-add step per cycle until the last bit of A.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start && !busy_reg) begin
      a_reg    <= a;
      b_reg    <= {{WIDTH{1'b0}}, b};
      acc_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      acc_reg <= acc_next;
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg << 1;
      cnt_reg <= cnt_reg + 1'b1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Datapath ALU with valid/ready handshake. Single-cycle ops retire one cycle after issue;
// MUL is handed to the iterative multiplier and holds ready low until it retires.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       control,
  input  logic             load,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  output logic             ready,
  output logic             valid_dout,
  output logic [WIDTH-1:0] dout,
  output logic [2:0]       flags
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               issue;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   res_next;
  logic               carry_next;
  logic               ovf_next;
  logic [2:0]         flags_next;
  logic [2:0]         mul_flags;

  logic [WIDTH-1:0]   dout_reg;
  logic [2:0]         flags_reg;
  logic               valid_reg;

  // The unit is idle whenever no multiply is in flight; reset forces it not-ready.
  assign ready     = !reset && !mul_busy;
  assign issue     = load && ready;
  assign mul_start = issue && (control == OP_MUL);

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (din_a),
    .b       (din_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle result and carry/overflow; MUL and NOP fall through to zero here.
  always_comb begin
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (control)
      OP_ADD: begin
        {carry_next, res_next} = {1'b0, din_b} + {1'b0, din_a};
        ovf_next = (din_a[WIDTH-1] == din_b[WIDTH-1]) &&
                   (res_next[WIDTH-1] != din_b[WIDTH-1]);
      end
      OP_SUB: begin
        res_next   = din_b - din_a;
        carry_next = (din_b < din_a);
        ovf_next   = (din_a[WIDTH-1] != din_b[WIDTH-1]) &&
                     (res_next[WIDTH-1] != din_b[WIDTH-1]);
      end
      OP_AND:  res_next = din_b & din_a;
      OP_OR:   res_next = din_b | din_a;
      OP_XOR:  res_next = din_b ^ din_a;
      OP_SHL:  res_next = din_b << din_a[SHW-1:0];
      default: res_next = '0;
    endcase
  end

  // Pack flags for both result sources; MUL carry reports a non-zero high half.
  always_comb begin
    flags_next            = '0;
    flags_next[FLG_ZERO]  = (res_next == '0);
    flags_next[FLG_CARRY] = carry_next;
    flags_next[FLG_OVF]   = ovf_next;
    mul_flags             = '0;
    mul_flags[FLG_ZERO]   = (mul_product[WIDTH-1:0] == '0);
    mul_flags[FLG_CARRY]  = |mul_product[2*WIDTH-1:WIDTH];
  end

  // Output registers: update only when a result retires, with a one-cycle valid pulse.
  // A retiring MUL and a new issue cannot coincide because ready is low while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_reg  <= '0;
      flags_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (mul_done) begin
        dout_reg  <= mul_product[WIDTH-1:0];
        flags_reg <= mul_flags;
        valid_reg <= 1'b1;
      end else if (issue && (control != OP_MUL)) begin
        dout_reg  <= res_next;
        flags_reg <= flags_next;
        valid_reg <= 1'b1;
      end
    end
  end

  assign dout       = dout_reg;
  assign flags      = flags_reg;
  assign valid_dout = valid_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=16: directed vector table, hand-written multi-cycle sequences,
// and random transactions checked against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [2:0]   control;
  logic         load;
  logic [W-1:0] din_a;
  logic [W-1:0] din_b;
  logic         ready;
  logic         valid_dout;
  logic [W-1:0] dout;
  logic [2:0]   flags;

  int checks   = 0;
  int failures = 0;

  alu_pipe #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .control    (control),
    .load       (load),
    .din_a      (din_a),
    .din_b      (din_b),
    .ready      (ready),
    .valid_dout (valid_dout),
    .dout       (dout),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_dout;
    logic [2:0]   exp_flags;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {ovf, carry, zero, result} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    int     r;
    int     s;
    int     ss;
    longint p;
    logic   c;
    logic   v;
    r = 0; c = 1'b0; v = 1'b0;
    case (op)
      3'd1: begin
        s  = int'(b) + int'(a);
        r  = s & 'hFFFF;
        c  = (s > 65535);
        ss = int'($signed(b)) + int'($signed(a));
        v  = (ss > 32767) || (ss < -32768);
      end
      3'd2: begin
        s  = int'(b) - int'(a);
        r  = s & 'hFFFF;
        c  = (b < a);
        ss = int'($signed(b)) - int'($signed(a));
        v  = (ss > 32767) || (ss < -32768);
      end
      3'd3: begin
        p = longint'(b) * longint'(a);
        r = int'(p & 64'hFFFF);
        c = ((p >> 16) != 0);
      end
      3'd4: r = int'(b & a);
      3'd5: r = int'(b | a);
      3'd6: r = int'(b ^ a);
      3'd7: r = (int'(b) << a[3:0]) & 'hFFFF;
      default: r = 0;
    endcase
    return {v, c, (r == 0), r[15:0]};
  endfunction

  // Issue one op, throw ignored garbage loads at the unit while it is busy, then
  // check latency, result and the single-cycle valid pulse.
  task automatic run_txn(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_d,
                         input logic [2:0] exp_f);
    int cycles;
    int exp_lat;
    exp_lat = (op == OP_MUL) ? W + 1 : 1;
    check({name, "_ready"}, 32'(ready), 32'd1);
    control = op; din_a = a; din_b = b; load = 1'b1;
    step();
    load = 1'b0;
    cycles = 1;
    while (valid_dout !== 1'b1 && cycles < W + 4) begin
      load    = 1'($urandom_range(0, 1));
      control = 3'($urandom_range(0, 7));
      din_a   = W'($urandom);
      din_b   = W'($urandom);
      step();
      load = 1'b0;
      cycles++;
    end
    check({name, "_valid"}, 32'(valid_dout), 32'd1);
    check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({name, "_dout"}, 32'(dout), 32'(exp_d));
    check({name, "_flags"}, 32'(flags), 32'(exp_f));
    $display("txn %s op=%0d b=%h a=%h dout=%h flags=%b lat=%0d", name, op, b, a, dout, flags, cycles);
    step();
    check({name, "_pulse"}, 32'(valid_dout), 32'd0);
  endtask

  initial begin
    logic [18:0] m;
    logic [2:0]  rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int vcount;

    vecs[0] = '{OP_ADD, 16'h0001, 16'hFFFF, 16'h0000, 3'b011};
    vecs[1] = '{OP_ADD, 16'h0001, 16'h7FFF, 16'h8000, 3'b100};
    vecs[2] = '{OP_SUB, 16'h0005, 16'h0003, 16'hFFFE, 3'b010};
    vecs[3] = '{OP_MUL, 16'h0101, 16'h0100, 16'h0100, 3'b010};
    vecs[4] = '{OP_AND, 16'hFF00, 16'hF0F0, 16'hF000, 3'b000};
    vecs[5] = '{OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 3'b000};
    vecs[6] = '{OP_SUB, 16'h0001, 16'h8000, 16'h7FFF, 3'b100};
    vecs[7] = '{OP_SHL, 16'h0011, 16'h8001, 16'h0002, 3'b000};
    vecs[8] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b010};
    vecs[9] = '{OP_AND, 16'hFF00, 16'h00FF, 16'h0000, 3'b001};

    reset = 1'b1; load = 1'b0; control = 3'd0; din_a = '0; din_b = '0;
    step();
    step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", 32'(valid_dout), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(ready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].exp_dout, vecs[i].exp_flags);
    end

    // MUL with ADD loads held during busy; the held load is accepted at N+17.
    control = OP_MUL; din_b = 16'h0100; din_a = 16'h0101; load = 1'b1;
    step();
    control = OP_ADD; din_b = 16'h0002; din_a = 16'h0001;
    vcount = 0;
    for (int i = 1; i <= W; i++) begin
      if (ready !== 1'b0) vcount++;
      if (valid_dout !== 1'b0) vcount++;
      step();
    end
    check("mulbusy_ready_valid_low", 32'(vcount), 32'd0);
    check("mulbusy_valid", 32'(valid_dout), 32'd1);
    check("mulbusy_ready", 32'(ready), 32'd1);
    check("mulbusy_dout", 32'(dout), 32'h0100);
    check("mulbusy_flags", 32'(flags), 32'b010);
    step();
    load = 1'b0;
    check("after_mul_add_valid", 32'(valid_dout), 32'd1);
    check("after_mul_add_dout", 32'(dout), 32'h0003);
    check("after_mul_add_flags", 32'(flags), 32'b000);
    $display("txn mul_then_add dout=%h flags=%b", dout, flags);
    step();
    check("after_mul_add_pulse", 32'(valid_dout), 32'd0);

    // Reset during cycle N+5 of a MUL aborts it.
    control = OP_MUL; din_b = 16'h1234; din_a = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    check("midrst_ready_in_reset", 32'(ready), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    vcount = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (valid_dout !== 1'b0) vcount++;
      step();
    end
    check("midrst_no_valid", 32'(vcount), 32'd0);
    $display("txn mul_reset_abort ready=%0d dout=%h", ready, dout);

    // Back-to-back single-cycle ops on consecutive cycles.
    control = OP_XOR; din_b = 16'hF0F0; din_a = 16'h0FF0; load = 1'b1;
    step();
    check("b2b_xor_valid", 32'(valid_dout), 32'd1);
    check("b2b_xor_dout", 32'(dout), 32'hFF00);
    check("b2b_xor_flags", 32'(flags), 32'b000);
    control = OP_SHL; din_b = 16'h0001; din_a = 16'h000F;
    step();
    check("b2b_shl_valid", 32'(valid_dout), 32'd1);
    check("b2b_shl_dout", 32'(dout), 32'h8000);
    check("b2b_shl_flags", 32'(flags), 32'b000);
    control = OP_NOP; din_b = 16'h1234; din_a = 16'h4321;
    step();
    load = 1'b0;
    check("b2b_nop_valid", 32'(valid_dout), 32'd1);
    check("b2b_nop_dout", 32'(dout), 32'h0000);
    check("b2b_nop_flags", 32'(flags), 32'b001);
    $display("txn back_to_back xor/shl/nop done");
    step();
    check("b2b_pulse", 32'(valid_dout), 32'd0);

    // Random transactions against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'hFFFF;
        1: rb = 16'h8000;
        2: rb = 16'h7FFF;
        3: ra = 16'h0000;
        default: ;
      endcase
      m = model(rop, ra, rb);
      run_txn($sformatf("rnd%0d", i), rop, ra, rb, m[15:0], m[18:16]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
